// File: rtl/frogger_pkg.sv
// -----------------------------------------------------------------------------
// frogger_pkg
// Shared types and constants for the Frogger round timer.
//   timer_state_t : round timer FSM states
//   SECS_W        : width of the binary seconds count
//   BCD_W         : width of one BCD display digit
//   CLK_HZ        : system clock frequency
//   sat_secs()    : clamp a widened seconds value to a ceiling
// -----------------------------------------------------------------------------
package frogger_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} timer_state_t;

   localparam int SECS_W = 7;
   localparam int BCD_W  = 4;
   localparam int CLK_HZ = 50_000_000;

   // v carries one extra bit so that count + add can never wrap before clamping.
   function automatic logic [SECS_W-1:0] sat_secs(input logic [SECS_W:0] v,
                                                  input logic [SECS_W:0] lim);
      return (v > lim) ? lim[SECS_W-1:0] : v[SECS_W-1:0];
   endfunction

endpackage

// File: rtl/round_timer_if.sv
// -----------------------------------------------------------------------------
// round_timer_if
// Control/status bundle between the game logic and the round timer.
//   clk_1Hz, start, pause, add_req, add_secs : toward the timer
//   secs_tens, secs_ones                     : BCD digits for the HUD
//   running, expired, expire_pulse, warn     : status for the game FSM
// master: game side (drives the controls). slave: the timer.
// -----------------------------------------------------------------------------
interface round_timer_if;
   import frogger_pkg::*;

   logic             clk_1Hz;
   logic             start;
   logic             pause;
   logic             add_req;
   logic [3:0]       add_secs;
   logic [BCD_W-1:0] secs_tens;
   logic [BCD_W-1:0] secs_ones;
   logic             running;
   logic             expired;
   logic             expire_pulse;
   logic             warn;

   modport master (
      output clk_1Hz, start, pause, add_req, add_secs,
      input  secs_tens, secs_ones, running, expired, expire_pulse, warn
   );

   modport slave (
      input  clk_1Hz, start, pause, add_req, add_secs,
      output secs_tens, secs_ones, running, expired, expire_pulse, warn
   );

endinterface

// File: rtl/round_timer_bin_to_bcd.sv
// -----------------------------------------------------------------------------
// bin_to_bcd
// Combinational 7-bit binary to two BCD digits, valid for 0..99.
//   i_bin  : binary value
//   o_tens : BCD tens digit
//   o_ones : BCD ones digit
// -----------------------------------------------------------------------------
module bin_to_bcd
   import frogger_pkg::*;
(
   input  logic [SECS_W-1:0] i_bin,
   output logic [BCD_W-1:0]  o_tens,
   output logic [BCD_W-1:0]  o_ones
);

   logic [BCD_W-1:0] w_tens;
   logic [BCD_W-1:0] w_ones;

   // Threshold ladder instead of a divider: the largest multiple of ten not
   // exceeding the input gives the tens digit.
   always_comb begin
      w_tens = '0;
      for (int k = 1; k < 10; k++) begin
         if (i_bin >= SECS_W'(k * 10)) w_tens = BCD_W'(k);
      end
      w_ones = BCD_W'(i_bin - SECS_W'(w_tens) * SECS_W'(10));
   end

   assign o_tens = w_tens;
   assign o_ones = w_ones;

endmodule

// File: rtl/round_timer.sv
// -----------------------------------------------------------------------------
// round_timer
// Frogger round countdown timer. The 1 Hz square wave is sampled as data,
// synchronised and rising-edge detected to form a one-cycle tick; the count
// decrements once per tick while running and is shown as two BCD digits.
//   Clk   : 50 MHz system clock
//   reset : asynchronous active-high reset
//   bus   : round_timer_if.slave (controls in, digits/status out)
// Parameters: START_SECS (reload value), WARN_SECS (warn threshold),
//             MAX_SECS (count ceiling, <= 99).
// Optional feature: define TIME_ADD_EN to let add_req/add_secs extend the
// round while running or paused; otherwise those inputs are ignored.
// -----------------------------------------------------------------------------
module round_timer
   import frogger_pkg::*;
#(
   parameter int START_SECS = 60,
   parameter int WARN_SECS  = 10,
   parameter int MAX_SECS   = 99
)(
   input  logic         Clk,
   input  logic         reset,
   round_timer_if.slave bus
);

   logic              r_s1, r_s2, r_s3;
   timer_state_t      r_state;
   logic [SECS_W-1:0] r_count;
   logic              r_running;
   logic              r_expired;
   logic              r_expire_pulse;

   logic              w_tick;
   logic              w_dec;
   logic [3:0]        w_add;
   logic [SECS_W-1:0] w_base;
   logic [SECS_W:0]   w_sum;
   logic [SECS_W-1:0] w_new_count;

   assign w_tick = r_s2 & ~r_s3;

`ifdef TIME_ADD_EN
   assign w_add = bus.add_req ? bus.add_secs : 4'd0;
`else
   logic w_unused_add;
   assign w_unused_add = bus.add_req ^ (^bus.add_secs);
   assign w_add = 4'd0;
`endif

   // Only a tick in RUN with pause low counts; pause outranks the tick.
   // The count here is always >= 1 in RUN, so the decrement cannot wrap.
   assign w_dec       = (r_state == RUN) && !bus.pause && w_tick;
   assign w_base      = w_dec ? r_count - SECS_W'(1) : r_count;
   assign w_sum       = (SECS_W + 1)'(w_base) + (SECS_W + 1)'(w_add);
   assign w_new_count = sat_secs(w_sum, (SECS_W + 1)'(MAX_SECS));

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_s1           <= 1'b0;
         r_s2           <= 1'b0;
         r_s3           <= 1'b0;
         r_state        <= IDLE;
         r_count        <= SECS_W'(START_SECS);
         r_running      <= 1'b0;
         r_expired      <= 1'b0;
         r_expire_pulse <= 1'b0;
      end else begin
         r_s1           <= bus.clk_1Hz;
         r_s2           <= r_s1;
         r_s3           <= r_s2;
         r_expire_pulse <= 1'b0;
         if (bus.start) begin
            // start wins over everything, including the final tick.
            r_state   <= RUN;
            r_count   <= SECS_W'(START_SECS);
            r_running <= 1'b1;
            r_expired <= 1'b0;
         end else begin
            case (r_state)
               RUN: begin
                  r_count <= w_new_count;
                  if (bus.pause) begin
                     r_state   <= PAUSE;
                     r_running <= 1'b0;
                  end else if (w_new_count == '0) begin
                     r_state        <= EXPIRED;
                     r_running      <= 1'b0;
                     r_expired      <= 1'b1;
                     r_expire_pulse <= 1'b1;
                  end
               end
               PAUSE: begin
                  r_count <= w_new_count;
                  if (!bus.pause) begin
                     r_state   <= RUN;
                     r_running <= 1'b1;
                  end
               end
               default: ;  // IDLE and EXPIRED wait for start
            endcase
         end
      end
   end

   bin_to_bcd u_bcd (
      .i_bin  (r_count),
      .o_tens (bus.secs_tens),
      .o_ones (bus.secs_ones)
   );

   assign bus.running      = r_running;
   assign bus.expired      = r_expired;
   assign bus.expire_pulse = r_expire_pulse;
   assign bus.warn         = (r_state == RUN || r_state == PAUSE) &&
                             (r_count <= SECS_W'(WARN_SECS));

endmodule

// File: tb/tb_round_timer.sv
// -----------------------------------------------------------------------------
// tb_round_timer
// Directed bench for round_timer. Instance A uses the default 60 s round,
// instance B a 3 s round for expiry corner cases. The 1 Hz input is toggled
// at an accelerated rate (4 cycles high, 4+ cycles low per "second").
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_round_timer;

   logic Clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   pulses;

   always #5 Clk = ~Clk;

   round_timer_if bus_a ();
   round_timer_if bus_b ();

   round_timer #(.START_SECS(60), .WARN_SECS(10), .MAX_SECS(99)) dut_a (
      .Clk   (Clk),
      .reset (reset),
      .bus   (bus_a)
   );

   round_timer #(.START_SECS(3), .WARN_SECS(10), .MAX_SECS(99)) dut_b (
      .Clk   (Clk),
      .reset (reset),
      .bus   (bus_b)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_a(input string tag, input int tens, input int ones);
      check({tag, "_tens"}, int'(bus_a.secs_tens), tens);
      check({tag, "_ones"}, int'(bus_a.secs_ones), ones);
   endtask

   task automatic check_b(input string tag, input int tens, input int ones);
      check({tag, "_tens"}, int'(bus_b.secs_tens), tens);
      check({tag, "_ones"}, int'(bus_b.secs_ones), ones);
   endtask

   // One rising edge on A's 1 Hz input; returns after the tick has acted.
   task automatic edge_a();
      @(negedge Clk) bus_a.clk_1Hz = 1'b1;
      repeat (4) @(negedge Clk);
      bus_a.clk_1Hz = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   // One rising edge on B; start/add can be driven into the exact cycle in
   // which the tick acts (third posedge after the raise). Counts expire pulses.
   task automatic edge_b(input bit do_start, input bit do_add,
                         input logic [3:0] secs, output int np);
      np = 0;
      @(negedge Clk) bus_b.clk_1Hz = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      bus_b.start    = do_start;
      bus_b.add_req  = do_add;
      bus_b.add_secs = secs;
      @(negedge Clk);
      bus_b.start   = 1'b0;
      bus_b.add_req = 1'b0;
      if (bus_b.expire_pulse) np++;
      bus_b.clk_1Hz = 1'b0;
      repeat (5) begin
         @(negedge Clk);
         if (bus_b.expire_pulse) np++;
      end
   endtask

   task automatic start_a();
      @(negedge Clk) bus_a.start = 1'b1;
      @(negedge Clk) bus_a.start = 1'b0;
   endtask

   task automatic add_a(input logic [3:0] secs);
      @(negedge Clk) begin bus_a.add_req = 1'b1; bus_a.add_secs = secs; end
      @(negedge Clk) bus_a.add_req = 1'b0;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus_a.clk_1Hz = 1'b0; bus_a.start = 1'b0; bus_a.pause = 1'b0;
      bus_a.add_req = 1'b0; bus_a.add_secs = 4'd0;
      bus_b.clk_1Hz = 1'b0; bus_b.start = 1'b0; bus_b.pause = 1'b0;
      bus_b.add_req = 1'b0; bus_b.add_secs = 4'd0;

      // Reset state
      repeat (3) @(negedge Clk);
      check_a("rst_a", 6, 0);
      check("rst_running", int'(bus_a.running), 0);
      check("rst_expired", int'(bus_a.expired), 0);
      check("rst_pulse", int'(bus_a.expire_pulse), 0);
      check("rst_warn", int'(bus_a.warn), 0);
      check_b("rst_b", 0, 3);
      reset = 1'b0;
      edge_a();
      check_a("idle_no_dec", 6, 0);

      // 1. start then three seconds: 60 -> 57
      start_a();
      check("start_running", int'(bus_a.running), 1);
      repeat (3) edge_a();
      check_a("cnt57", 5, 7);
      check("cnt57_running", int'(bus_a.running), 1);
      check("cnt57_warn", int'(bus_a.warn), 0);

      // 3. pause across two edges, then one more edge after release
      @(negedge Clk) bus_a.pause = 1'b1;
      repeat (2) edge_a();
      check_a("paused57", 5, 7);
      check("paused_running", int'(bus_a.running), 0);
      @(negedge Clk) bus_a.pause = 1'b0;
      @(negedge Clk);
      check("unpause_running", int'(bus_a.running), 1);
      edge_a();
      check_a("cnt56", 5, 6);

      // 5. run down to 42, then reset mid-round
      repeat (14) edge_a();
      check_a("cnt42", 4, 2);
      @(negedge Clk) reset = 1'b1;
      #1;
      check_a("async_rst", 6, 0);
      check("async_rst_running", int'(bus_a.running), 0);
      check("async_rst_warn", int'(bus_a.warn), 0);
      @(negedge Clk) reset = 1'b0;
      repeat (2) edge_a();
      check_a("post_rst_idle", 6, 0);
      check("post_rst_running", int'(bus_a.running), 0);

      // 3 (cont). warn threshold at 10
      start_a();
      repeat (49) edge_a();
      check_a("cnt11", 1, 1);
      check("cnt11_warn", int'(bus_a.warn), 0);
      edge_a();
      check_a("cnt10", 1, 0);
      check("cnt10_warn", int'(bus_a.warn), 1);
      @(negedge Clk) bus_a.pause = 1'b1;
      @(negedge Clk);
      check("pause10_warn", int'(bus_a.warn), 1);
      check("pause10_running", int'(bus_a.running), 0);

      // 6a. time add while paused
`ifdef TIME_ADD_EN
      repeat (5) add_a(4'd15);
      check_a("add85", 8, 5);
      add_a(4'd10);
      check_a("add95", 9, 5);
      add_a(4'd9);
      check_a("add_sat99", 9, 9);
      add_a(4'd15);
      check_a("add_sat_hold", 9, 9);
`else
      add_a(4'd9);
      check_a("add_ignored", 1, 0);
`endif
      @(negedge Clk) bus_a.pause = 1'b0;

      // 2. 3 s round on B: expiry
      @(negedge Clk) bus_b.start = 1'b1;
      @(negedge Clk) bus_b.start = 1'b0;
      edge_b(1'b0, 1'b0, 4'd0, pulses);
      edge_b(1'b0, 1'b0, 4'd0, pulses);
      check_b("b_cnt1", 0, 1);
      check("b_cnt1_pulses", pulses, 0);
      check("b_cnt1_warn", int'(bus_b.warn), 1);
      edge_b(1'b0, 1'b0, 4'd0, pulses);
      check("b_expire_pulses", pulses, 1);
      check_b("b_expired", 0, 0);
      check("b_expired_lvl", int'(bus_b.expired), 1);
      check("b_expired_running", int'(bus_b.running), 0);
      check("b_expired_warn", int'(bus_b.warn), 0);
      edge_b(1'b0, 1'b0, 4'd0, pulses);
      check_b("b_no_underflow", 0, 0);
      check("b_no_repulse", pulses, 0);

      // 4. start coincident with the final tick
      @(negedge Clk) bus_b.start = 1'b1;
      @(negedge Clk) bus_b.start = 1'b0;
      check("b_restart_expired", int'(bus_b.expired), 0);
      repeat (2) edge_b(1'b0, 1'b0, 4'd0, pulses);
      check_b("b_cnt1_again", 0, 1);
      edge_b(1'b1, 1'b0, 4'd0, pulses);
      check("b_start_wins_pulses", pulses, 0);
      check_b("b_start_wins", 0, 3);
      check("b_start_wins_running", int'(bus_b.running), 1);
      check("b_start_wins_expired", int'(bus_b.expired), 0);

      // 6b. add coincident with the final tick
      repeat (2) edge_b(1'b0, 1'b0, 4'd0, pulses);
      edge_b(1'b0, 1'b1, 4'd5, pulses);
`ifdef TIME_ADD_EN
      check_b("b_add_tick", 0, 5);
      check("b_add_tick_pulses", pulses, 0);
      check("b_add_tick_running", int'(bus_b.running), 1);
`else
      check_b("b_add_ignored", 0, 0);
      check("b_add_ignored_pulses", pulses, 1);
      check("b_add_ignored_expired", int'(bus_b.expired), 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
